// File: rtl/path_sequencer_pkg.sv
// Shared path definitions: default path geometry, the invalid-node code and
// sequencer state encodings, used by pathDecode and the path sequencer.
package path_sequencer_pkg;

    localparam int NODE_W_DEF   = 5;
    localparam int SLOTS_DEF    = 20;
    localparam int NODE_INVALID = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/path_slot_mux.sv
// Selects one node ID out of a packed path word; slot 0 occupies the
// lowest-numbered bits of the word.
module path_slot_mux
    import path_sequencer_pkg::*;
#(
    parameter int NODE_W = NODE_W_DEF,
    parameter int SLOTS  = SLOTS_DEF,
    parameter int IDX_W  = 5
) (
    input  logic [0:NODE_W*SLOTS-1] path,
    input  logic [IDX_W-1:0]        idx,
    output logic [0:NODE_W-1]       node
);

    always_comb begin
        node = '0;
        for (int k = 0; k < SLOTS; k++) begin
            if (idx == IDX_W'(k))
                node = path[NODE_W*k +: NODE_W];
        end
    end

endmodule

// File: rtl/path_sequencer.sv
// Walks a captured path word slot by slot, handing each waypoint to the
// motion stage with valid/ready until end_node is accepted or the path is bad.
module path_sequencer
    import path_sequencer_pkg::*;
#(
    parameter int NODE_W = NODE_W_DEF,
    parameter int SLOTS  = SLOTS_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [0:NODE_W*SLOTS-1] path_in,
    input  logic [0:NODE_W-1]       end_node,
    input  logic                    path_valid,
    output logic                    path_ready,
    output logic [0:NODE_W-1]       node_out,
    output logic                    node_valid,
    input  logic                    node_ready,
    output logic [0:NODE_W-1]       hop_count,
    output logic                    done,
    output logic                    error
);

    localparam int IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SLOTS - 1);

    seq_state_t state_q, state_d;

    logic [0:NODE_W*SLOTS-1] path_q;
    logic [0:NODE_W-1]       end_q;
    logic [IDX_W-1:0]        idx_q;
    logic [0:NODE_W-1]       hop_q;
    logic [0:NODE_W-1]       cur_node;
    logic                    slot_zero, is_end, accept;

    path_slot_mux #(
        .NODE_W (NODE_W),
        .SLOTS  (SLOTS),
        .IDX_W  (IDX_W)
    ) u_slot_mux (
        .path (path_q),
        .idx  (idx_q),
        .node (cur_node)
    );

    assign slot_zero = (cur_node == NODE_W'(NODE_INVALID));
    assign is_end    = (cur_node == end_q);
    assign accept    = node_valid & node_ready;
    assign hop_count = hop_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        path_ready = 1'b0;
        node_valid = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                path_ready = 1'b1;
                if (path_valid) state_d = ST_EMIT;
            end
            ST_EMIT: begin
                // An invalid slot is never presented downstream.
                if (slot_zero) begin
                    state_d = ST_ERR;
                end else begin
                    node_valid = 1'b1;
                    if (node_ready) begin
                        if (is_end)                 state_d = ST_DONE;
                        else if (idx_q == IDX_LAST) state_d = ST_ERR;
                    end
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                error   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        node_out = node_valid ? cur_node : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            path_q <= '0;
            end_q  <= '0;
            idx_q  <= '0;
            hop_q  <= '0;
        end else if (state_q == ST_IDLE && path_valid) begin
            path_q <= path_in;
            end_q  <= end_node;
            idx_q  <= '0;
            hop_q  <= '0;
        end else if (accept) begin
            if (hop_q != '1) hop_q <= hop_q + 1'b1;
            // idx stays put on the final accept so it never passes the last slot.
            if (!is_end && idx_q != IDX_LAST) idx_q <= idx_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_path_sequencer.sv
// Randomized and directed bench for path_sequencer against a slot-walk model.
module tb_path_sequencer;
    localparam int NW = 5;
    localparam int SL = 20;
    localparam int PW = NW * SL;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [0:PW-1] path_in;
    logic [0:NW-1] end_node;
    logic          path_valid;
    logic          path_ready;
    logic [0:NW-1] node_out;
    logic          node_valid;
    logic          node_ready;
    logic [0:NW-1] hop_count;
    logic          done;
    logic          error;

    int checks = 0;
    int errors = 0;
    int slots[SL];

    path_sequencer #(.NODE_W(NW), .SLOTS(SL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .path_in    (path_in),
        .end_node   (end_node),
        .path_valid (path_valid),
        .path_ready (path_ready),
        .node_out   (node_out),
        .node_valid (node_valid),
        .node_ready (node_ready),
        .hop_count  (hop_count),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic [0:PW-1] pack_slots();
        logic [0:PW-1] w;
        w = '0;
        for (int k = 0; k < SL; k++) w[NW*k +: NW] = NW'(slots[k]);
        return w;
    endfunction

    task automatic clear_slots();
        for (int k = 0; k < SL; k++) slots[k] = 0;
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0,1..., 2: random ready
    task automatic run_path(input int endv, input int mode, input bit inject, input string tag);
        int  exp_q[$];
        bit  exp_done;
        int  exp_hop, pos, cyc, vcnt, prev_out;
        bit  prev_stall, saw_done, saw_err, rdy;
        logic [0:PW-1] pw;

        // Reference: walk slots until invalid, end, or the path runs out.
        exp_q.delete();
        exp_done = 1'b0;
        for (int k = 0; k < SL; k++) begin
            if (slots[k] == 0) break;
            exp_q.push_back(slots[k]);
            if (slots[k] == endv) begin exp_done = 1'b1; break; end
        end
        exp_hop = (exp_q.size() > 31) ? 31 : exp_q.size();

        pw = pack_slots();
        cyc = 0;
        while (!path_ready && cyc < 10) begin @(negedge clk); cyc++; end
        chk({tag, " ready"}, int'(path_ready), 1);
        path_in    = pw;
        end_node   = NW'(endv);
        path_valid = 1'b1;
        @(negedge clk);
        path_valid = 1'b0;
        if (inject) begin
            path_in    = ~pw;
            end_node   = NW'(endv ^ 5'h15);
            path_valid = 1'b1;
        end
        chk({tag, " lat"}, int'(node_valid), (exp_q.size() > 0) ? 1 : 0);
        chk({tag, " busy"}, int'(path_ready), 0);

        pos = 0; cyc = 0; vcnt = 0; prev_stall = 0; prev_out = 0;
        saw_done = 0; saw_err = 0;
        while (cyc < 200) begin
            if (done || error) begin
                saw_done   = done;
                saw_err    = error;
                path_valid = 1'b0;
                break;
            end
            if (node_valid) begin
                if (pos < exp_q.size()) chk({tag, " node"}, int'(node_out), exp_q[pos]);
                else                    chk({tag, " extra"}, int'(node_out), -1);
                if (prev_stall) chk({tag, " stable"}, int'(node_out), prev_out);
                case (mode)
                    0:       rdy = 1'b1;
                    1:       rdy = (vcnt % 3) == 0;
                    default: rdy = 1'($urandom_range(0, 1));
                endcase
                vcnt++;
                prev_stall = !rdy;
                prev_out   = int'(node_out);
                if (rdy) pos++;
            end else begin
                rdy = 1'($urandom_range(0, 1));
                prev_stall = 1'b0;
            end
            node_ready = rdy;
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 200) chk({tag, " timeout"}, cyc, 0);
        chk({tag, " done"}, int'(saw_done), int'(exp_done));
        chk({tag, " err"}, int'(saw_err), int'(!exp_done));
        chk({tag, " count"}, pos, exp_q.size());
        chk({tag, " hop"}, int'(hop_count), exp_hop);
        node_ready = 1'b0;
        @(negedge clk);
        chk({tag, " pulse"}, int'(done | error), 0);
        chk({tag, " idle"}, int'(path_ready), 1);
        chk({tag, " hold"}, int'(hop_count), exp_hop);
    endtask

    initial begin
        int len, endv;
        rst_n      = 1'b0;
        path_in    = '0;
        end_node   = '0;
        path_valid = 1'b0;
        node_ready = 1'b0;
        #12;
        chk("rst ready", int'(path_ready), 1);
        chk("rst valid", int'(node_valid), 0);
        chk("rst out", int'(node_out), 0);
        chk("rst hop", int'(hop_count), 0);
        chk("rst pulse", int'(done | error), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        clear_slots();
        slots[0] = 3; slots[1] = 4; slots[2] = 9; slots[3] = 14; slots[4] = 25;
        run_path(25, 0, 1'b0, "basic");
        run_path(25, 1, 1'b0, "stall");
        run_path(25, 0, 1'b1, "inject");

        slots[2] = 0; slots[3] = 0; slots[4] = 0;
        run_path(25, 0, 1'b0, "zero");

        for (int k = 0; k < SL; k++) slots[k] = k + 1;
        run_path(20, 2, 1'b0, "full");
        run_path(31, 0, 1'b0, "noend");

        // Reset after the second accept abandons the path silently.
        clear_slots();
        slots[0] = 3; slots[1] = 4; slots[2] = 9; slots[3] = 14; slots[4] = 25;
        path_in = pack_slots(); end_node = NW'(25); path_valid = 1'b1;
        @(negedge clk);
        path_valid = 1'b0;
        node_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("mid hop", int'(hop_count), 2);
        rst_n = 1'b0;
        #1;
        chk("mid valid", int'(node_valid), 0);
        chk("mid ready", int'(path_ready), 1);
        chk("mid hopclr", int'(hop_count), 0);
        @(negedge clk);
        chk("mid pulse", int'(done | error), 0);
        rst_n = 1'b1;
        node_ready = 1'b0;
        @(negedge clk);
        chk("mid pulse2", int'(done | error), 0);
        clear_slots();
        slots[0] = 7; slots[1] = 8;
        run_path(7, 0, 1'b0, "single");

        for (int t = 0; t < 30; t++) begin
            clear_slots();
            len = $urandom_range(1, SL);
            for (int k = 0; k < len; k++) slots[k] = $urandom_range(1, 31);
            if ($urandom_range(0, 3) == 0) slots[$urandom_range(0, len - 1)] = 0;
            endv = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 31)
                                                : slots[$urandom_range(0, len - 1)];
            if (endv == 0) endv = 1;
            run_path(endv, 2, 1'($urandom_range(0, 1)), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
